// File: rtl/match_unit_if.sv
// Handshake and operand bundle for the pattern-search unit.
// master = issuing pipeline stage, slave = match_unit.
interface match_unit_if #(parameter int DATA_W = 32);
  logic              start;
  logic              cancel;
  logic              mode_aligned;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              busy;
  logic              done;
  logic              found;
  logic [DATA_W-1:0] result;

  modport master (
    output start, cancel, mode_aligned, src1, src2,
    input  busy, done, found, result
  );

  modport slave (
    input  start, cancel, mode_aligned, src1, src2,
    output busy, done, found, result
  );
endinterface

// File: rtl/match_unit.sv
// Lowest-index search for src1[PAT_W-1:0] inside src2, STEP positions per cycle.
// Latency ceil(NPOS/STEP)+1 from accept; MATCH_EARLY_EXIT_EN ends the scan the cycle after the first hit.
// No backpressure: start is ignored while busy, cancel flushes to IDLE without a done pulse.
module match_unit #(
  parameter int DATA_W = 32,
  parameter int PAT_W  = 8,
  parameter int STEP   = 1
) (
  input  logic         clk,
  input  logic         rst,
  match_unit_if.slave  bus
);
  localparam int NPOS  = DATA_W - PAT_W + 1;
  localparam int POS_W = $clog2(DATA_W + STEP + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [POS_W-1:0]  base;
  logic [POS_W-1:0]  rec_idx;
  logic [POS_W-1:0]  hit_idx;
  logic [POS_W-1:0]  sel_idx;
  logic [POS_W-1:0]  pos;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  win;
  logic [DATA_W-1:0] src2_q;
  logic [DATA_W-1:0] result_q;
  logic              aligned_q;
  logic              rec_found;
  logic              found_q;
  logic              hit;
  logic              sel_found;
  logic              last_step;
  logic              scan_exit;

  // Walk the window top-down so the lowest matching position is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    pos     = '0;
    win     = '0;
    for (int j = STEP - 1; j >= 0; j--) begin
      pos = base + POS_W'(j);
      win = PAT_W'(src2_q >> pos);
      if ((pos < POS_W'(NPOS)) &&
          (!aligned_q || ((pos % POS_W'(PAT_W)) == '0)) &&
          (win == pat_q)) begin
        hit     = 1'b1;
        hit_idx = pos;
      end
    end
  end

  assign sel_found = rec_found | hit;
  assign sel_idx   = rec_found ? rec_idx : hit_idx;
  assign last_step = (base + POS_W'(STEP)) >= POS_W'(NPOS);

`ifdef MATCH_EARLY_EXIT_EN
  assign scan_exit = last_step | hit;
`else
  assign scan_exit = last_step;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      base      <= '0;
      rec_found <= 1'b0;
      rec_idx   <= '0;
      pat_q     <= '0;
      src2_q    <= '0;
      aligned_q <= 1'b0;
      found_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.cancel) begin
            pat_q     <= bus.src1[PAT_W-1:0];
            src2_q    <= bus.src2;
            aligned_q <= bus.mode_aligned;
            base      <= '0;
            rec_found <= 1'b0;
            rec_idx   <= '0;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (bus.cancel) begin
            state <= ST_IDLE;
          end else begin
            rec_found <= sel_found;
            rec_idx   <= sel_idx;
            if (scan_exit) begin
              // Visible outputs move only here, so a flushed scan leaves the last answer intact.
              found_q  <= sel_found;
              result_q <= sel_found ? DATA_W'(sel_idx) : '1;
              state    <= ST_DONE;
            end else begin
              base <= base + POS_W'(STEP);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = (state == ST_DONE);
  assign bus.found  = found_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_match_unit.sv
// Scoreboard bench for match_unit: one DUT at STEP=1 and one at STEP=4, expectations queued at issue.
// Monitors pop and compare on every done pulse; stray done pulses are flagged.
module tb_match_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

`ifdef MATCH_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct {
    logic        f;
    logic [31:0] r;
    int          c;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  match_unit_if #(.DATA_W(32)) u1_if ();
  match_unit_if #(.DATA_W(32)) u4_if ();

  match_unit #(.DATA_W(32), .PAT_W(8), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(u1_if));
  match_unit #(.DATA_W(32), .PAT_W(8), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(u4_if));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (u1_if.done === 1'b1) begin
      if (q1.size() == 0) begin
        chk("u1_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("u1_found", {31'd0, u1_if.found}, {31'd0, e.f});
        chk("u1_result", u1_if.result, e.r);
        chk("u1_done_cycle", cyc, e.c);
      end
    end
    if (u4_if.done === 1'b1) begin
      if (q4.size() == 0) begin
        chk("u4_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("u4_found", {31'd0, u4_if.found}, {31'd0, e.f});
        chk("u4_result", u4_if.result, e.r);
        chk("u4_done_cycle", cyc, e.c);
      end
    end
  end

  task automatic drive(input bit s4, input logic st, input logic [31:0] s1,
                       input logic [31:0] s2, input logic m);
    if (s4) begin
      u4_if.start = st; u4_if.src1 = s1; u4_if.src2 = s2; u4_if.mode_aligned = m;
    end else begin
      u1_if.start = st; u1_if.src1 = s1; u1_if.src2 = s2; u1_if.mode_aligned = m;
    end
  endtask

  task automatic do_op(input bit s4, input logic [31:0] s1, input logic [31:0] s2,
                       input logic m, input logic ef, input logic [31:0] er, input int lat);
    exp_t e;
    @(posedge clk); #1;
    drive(s4, 1'b1, s1, s2, m);
    e.f = ef; e.r = er; e.c = cyc + lat;
    if (s4) q4.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    drive(s4, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, ~m);
    for (int k = 0; k < 60; k++) begin
      if ((s4 ? q4.size() : q1.size()) == 0) break;
      @(posedge clk);
    end
    chk(s4 ? "u4_drain" : "u1_drain", s4 ? q4.size() : q1.size(), 32'd0);
    if (s4) q4.delete(); else q1.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    u1_if.cancel = 1'b0;
    u4_if.cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", {31'd0, u1_if.busy}, 32'd0);
    chk("reset_done", {31'd0, u1_if.done}, 32'd0);
    chk("reset_found", {31'd0, u1_if.found}, 32'd0);
    chk("reset_result", u1_if.result, 32'd0);

    // cancel and start together in IDLE: request must be refused
    drive(1'b0, 1'b1, 32'hAB, 32'hAB, 1'b0);
    u1_if.cancel = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    u1_if.cancel = 1'b0;
    chk("cancel_beats_start_busy", {31'd0, u1_if.busy}, 32'd0);

    do_op(1'b0, 32'h0000_00AB, 32'h0000_00AB, 1'b0, 1'b1, 32'd0, EE ? 2 : 26);
    do_op(1'b0, 32'h0000_00AB, 32'hAB00_0000, 1'b0, 1'b1, 32'd24, 26);
    do_op(1'b0, 32'h0000_00AB, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 26);
    do_op(1'b0, 32'h0000_000F, 32'h0000_00F0, 1'b1, 1'b0, 32'hFFFF_FFFF, 26);
    do_op(1'b0, 32'h0000_00AB, 32'hABAB_ABAB, 1'b0, 1'b1, 32'd0, EE ? 2 : 26);
    do_op(1'b1, 32'h0000_00AB, 32'hABAB_ABAB, 1'b0, 1'b1, 32'd0, EE ? 2 : 8);
    do_op(1'b1, 32'hFFFF_FF5A, 32'h5A00_0000, 1'b1, 1'b1, 32'd24, 8);
    do_op(1'b0, 32'h0000_000F, 32'h0000_00F0, 1'b0, 1'b1, 32'd4, EE ? 6 : 26);

    // cancel mid-scan: no done, outputs keep 0x4/found, stray starts ignored
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'hAB, 32'hAB00_0000, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      drive(1'b0, (k >= 2 && k <= 4), 32'hAB, 32'h0000_00AB, 1'b0);
      if (k == 5) begin
        chk("cancel_busy_before", {31'd0, u1_if.busy}, 32'd1);
        u1_if.cancel = 1'b1;
      end
    end
    @(posedge clk); #1;
    u1_if.cancel = 1'b0;
    chk("cancel_busy_after", {31'd0, u1_if.busy}, 32'd0);
    repeat (35) @(posedge clk);
    #1;
    chk("cancel_keep_found", {31'd0, u1_if.found}, 32'd1);
    chk("cancel_keep_result", u1_if.result, 32'd4);
    chk("cancel_idle", {31'd0, u1_if.busy}, 32'd0);

    // reset at scan cycle 10 clears outputs
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'hAB, 32'hAB00_0000, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      if (k == 9) chk("rst_busy_before", {31'd0, u1_if.busy}, 32'd1);
      if (k == 10) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy", {31'd0, u1_if.busy}, 32'd0);
    chk("rst_found", {31'd0, u1_if.found}, 32'd0);
    chk("rst_result", u1_if.result, 32'd0);

    do_op(1'b0, 32'h0000_00AB, 32'hAB00_0000, 1'b0, 1'b1, 32'd24, 26);
    do_op(1'b0, 32'h0000_00C3, 32'h000C_3000, 1'b0, 1'b1, 32'd12, EE ? 14 : 26);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
